// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing constants, state and coordinate types for the raster generator.
package vga_timing_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  typedef logic [9:0] coord_t;

  typedef enum logic {S_IDLE, S_RUN} vga_state_t;

  function automatic int h_total(input int vis, input int fp, input int sw, input int bp);
    return vis + fp + sw + bp;
  endfunction

  function automatic int v_total(input int vis, input int fp, input int sw, input int bp);
    return vis + fp + sw + bp;
  endfunction

  localparam int DEF_H_TOTAL = h_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int DEF_V_TOTAL = v_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Shift register that retimes {hs,vs} to match downstream RGB latency; resets to idle-high.
module sync_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] sync_in,
  output logic [1:0] sync_out
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign sync_out = sync_in;
    end else begin : g_shift
      logic [1:0] stage_q [DEPTH];
      logic [1:0] stage_d [DEPTH];

      always_comb begin
        stage_d[0] = sync_in;
        for (int i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= 2'b11;
          end
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= stage_d[i];
          end
        end
      end

      assign sync_out = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing source with frame pulses; define VGA_FRAME_COUNTER_EN
// to enable frame_count and anim_tick (otherwise both are tied to 0).
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter int SYNC_DELAY = 1,
  parameter int ANIM_DIV   = 4
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic       anim_tick,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL  = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL  = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  vga_state_t state_q, state_d;
  coord_t     x_q, x_d, y_q, y_d;
  logic       blank_q, blank_d;
  logic       frame_start_q, frame_start_d;
  logic       hs_raw_q, hs_raw_d, vs_raw_q, vs_raw_d;
  logic [1:0] sync_out;

  // Outputs are derived from the next counter values so they register alongside them.
  always_comb begin
    state_d = S_RUN;
    x_d     = x_q;
    y_d     = y_q;
    if (state_q == S_RUN) begin
      if (x_q == coord_t'(H_TOTAL - 1)) begin
        x_d = '0;
        y_d = (y_q == coord_t'(V_TOTAL - 1)) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
    blank_d       = (x_d < coord_t'(H_VISIBLE)) && (y_d < coord_t'(V_VISIBLE));
    frame_start_d = (x_d == '0) && (y_d == '0);
    hs_raw_d      = !((x_d >= coord_t'(HS_START)) && (x_d <= coord_t'(HS_END)));
    vs_raw_d      = !((y_d >= coord_t'(VS_START)) && (y_d <= coord_t'(VS_END)));
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      blank_q       <= 1'b0;
      frame_start_q <= 1'b0;
      hs_raw_q      <= 1'b1;
      vs_raw_q      <= 1'b1;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
      hs_raw_q      <= hs_raw_d;
      vs_raw_q      <= vs_raw_d;
    end
  end

  sync_delay_line #(
    .DEPTH(SYNC_DELAY)
  ) u_sync_delay (
    .clk     (vga_clk),
    .rst_n   (reset_n),
    .sync_in ({hs_raw_q, vs_raw_q}),
    .sync_out(sync_out)
  );

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign blank       = blank_q;
  assign frame_start = frame_start_q;
  assign hs          = sync_out[1];
  assign vs          = sync_out[0];

`ifdef VGA_FRAME_COUNTER_EN
  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  logic [7:0]       frame_count_q, frame_count_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             seen_q, seen_d;
  logic             anim_tick_q, anim_tick_d;

  // The very first frame_start after reset opens frame 0 and is not counted.
  always_comb begin
    frame_count_d = frame_count_q;
    div_d         = div_q;
    seen_d        = seen_q;
    anim_tick_d   = 1'b0;
    if (frame_start_d) begin
      seen_d = 1'b1;
      if (seen_q) begin
        frame_count_d = frame_count_q + 8'd1;
        if (div_q == DIV_W'(ANIM_DIV - 1)) begin
          div_d       = '0;
          anim_tick_d = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count_q <= '0;
      div_q         <= '0;
      seen_q        <= 1'b0;
      anim_tick_q   <= 1'b0;
    end else begin
      frame_count_q <= frame_count_d;
      div_q         <= div_d;
      seen_q        <= seen_d;
      anim_tick_q   <= anim_tick_d;
    end
  end

  assign frame_count = frame_count_q;
  assign anim_tick   = anim_tick_q;
`else
  assign frame_count = '0;
  assign anim_tick   = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a shrunken 8x5 raster; two instances cover
// SYNC_DELAY=0/ANIM_DIV=4 and SYNC_DELAY=2/ANIM_DIV=1.
module tb_vga_timing_gen;

  localparam int HV = 4, HF = 1, HSW = 2, HB = 1;
  localparam int VV = 2, VF = 1, VSW = 1, VB = 1;
  localparam int HT = 8, VT = 5, FRAME = HT * VT;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] x_a, y_a, x_b, y_b;
  logic       blank_a, hs_a, vs_a, fs_a, tick_a;
  logic       blank_b, hs_b, vs_b, fs_b, tick_b;
  logic [7:0] fc_a, fc_b;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .SYNC_DELAY(0), .ANIM_DIV(4)
  ) dut_a (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(x_a), .DrawY(y_a), .blank(blank_a),
    .hs(hs_a), .vs(vs_a), .frame_start(fs_a), .anim_tick(tick_a), .frame_count(fc_a)
  );

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .SYNC_DELAY(2), .ANIM_DIV(1)
  ) dut_b (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(x_b), .DrawY(y_b), .blank(blank_b),
    .hs(hs_b), .vs(vs_b), .frame_start(fs_b), .anim_tick(tick_b), .frame_count(fc_b)
  );

  typedef struct {
    int         kind;
    int         t;
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       fs;
    logic       hs_a;
    logic       vs_a;
    logic       hs_b;
    logic       vs_b;
    logic [7:0] fc;
    logic       tick_a;
    logic       tick_b;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Raw sync for edge t after release; before the first edge everything idles high.
  function automatic logic rawHs(input int t);
    int x;
    if (t < 0) return 1'b1;
    x = (t % FRAME) % HT;
    return !((x >= HV + HF) && (x <= HV + HF + HSW - 1));
  endfunction

  function automatic logic rawVs(input int t);
    int y;
    if (t < 0) return 1'b1;
    y = (t % FRAME) / HT;
    return !((y >= VV + VF) && (y <= VV + VF + VSW - 1));
  endfunction

  function automatic exp_t expAt(input int t);
    exp_t e;
    int pos, x, y;
    pos      = t % FRAME;
    x        = pos % HT;
    y        = pos / HT;
    e.kind   = 0;
    e.t      = t;
    e.x      = 10'(x);
    e.y      = 10'(y);
    e.blank  = (x < HV) && (y < VV);
    e.fs     = (pos == 0);
    e.hs_a   = rawHs(t);
    e.vs_a   = rawVs(t);
    e.hs_b   = rawHs(t - 2);
    e.vs_b   = rawVs(t - 2);
`ifdef VGA_FRAME_COUNTER_EN
    begin
      int f;
      f        = t / FRAME;
      e.fc     = 8'(f % 256);
      e.tick_a = (pos == 0) && (f > 0) && (f % 4 == 0);
      e.tick_b = (pos == 0) && (f > 0);
    end
`else
    e.fc     = 8'd0;
    e.tick_a = 1'b0;
    e.tick_b = 1'b0;
`endif
    return e;
  endfunction

  function automatic exp_t resetVec();
    exp_t e;
    e.kind   = 1;
    e.t      = 0;
    e.x      = '0;
    e.y      = '0;
    e.blank  = 1'b0;
    e.fs     = 1'b0;
    e.hs_a   = 1'b1;
    e.vs_a   = 1'b1;
    e.hs_b   = 1'b1;
    e.vs_b   = 1'b1;
    e.fc     = 8'd0;
    e.tick_a = 1'b0;
    e.tick_b = 1'b0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input exp_t e, input logic [9:0] act,
                             input logic [9:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s (%s t=%0d): got %0d, expected %0d",
               name, (e.kind == 1) ? "reset" : "run", e.t, act, req);
    end
  endtask

  // Monitor: the DUTs present outputs every cycle, compared mid-cycle on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        checkOutput("DrawX_a", e, x_a, e.x);
        checkOutput("DrawY_a", e, y_a, e.y);
        checkOutput("blank_a", e, 10'(blank_a), 10'(e.blank));
        checkOutput("hs_a", e, 10'(hs_a), 10'(e.hs_a));
        checkOutput("vs_a", e, 10'(vs_a), 10'(e.vs_a));
        checkOutput("frame_start_a", e, 10'(fs_a), 10'(e.fs));
        checkOutput("frame_count_a", e, 10'(fc_a), 10'(e.fc));
        checkOutput("anim_tick_a", e, 10'(tick_a), 10'(e.tick_a));
        checkOutput("DrawX_b", e, x_b, e.x);
        checkOutput("DrawY_b", e, y_b, e.y);
        checkOutput("blank_b", e, 10'(blank_b), 10'(e.blank));
        checkOutput("hs_b", e, 10'(hs_b), 10'(e.hs_b));
        checkOutput("vs_b", e, 10'(vs_b), 10'(e.vs_b));
        checkOutput("frame_start_b", e, 10'(fs_b), 10'(e.fs));
        checkOutput("frame_count_b", e, 10'(fc_b), 10'(e.fc));
        checkOutput("anim_tick_b", e, 10'(tick_b), 10'(e.tick_b));
      end
    end
  end

  task automatic holdReset(input int n);
    repeat (n) begin
      @(posedge clk);
      sbq.push_back(resetVec());
    end
    #2 reset_n = 1'b1;
  endtask

  task automatic applyStimulus(input int n);
    for (int t = 0; t < n; t++) begin
      @(posedge clk);
      sbq.push_back(expAt(t));
    end
  endtask

  // Reset lands just after an edge, so the monitor sees it before any further edge.
  task automatic midReset();
    @(posedge clk);
    #1 reset_n = 1'b0;
    sbq.push_back(resetVec());
  endtask

  initial begin
    reset_n = 1'b0;
    holdReset(5);
    applyStimulus(10);
    midReset();
    holdReset(3);
    applyStimulus(29);
    midReset();
    holdReset(2);
    applyStimulus(257 * FRAME + 5);
    repeat (2) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
